// File: rtl/shrimp_decode_if.sv
// shrimp_decode_if: fetch-side and issue-side handshake bundle of the decode stage.
// slave = decode stage, master = fetch/downstream environment.
interface shrimp_decode_if #(
  parameter int PC_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            syscall_done;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_opcode;
  logic [3:0]      out_ra;
  logic [3:0]      out_rb;
  logic [3:0]      out_rd;
  logic [15:0]     out_imm;
  logic            out_use_a;
  logic            out_use_b;
  logic            out_rf_we;
  logic            out_mem_re;
  logic            out_mem_we;
  logic            out_mem_byte;
  logic            out_branch;
  logic            out_syscall;
  logic [PC_W-1:0] out_pc;
  logic            in_sys_wait;

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  flush, syscall_done, out_ready,
    output in_ready, in_sys_wait, out_valid,
    output out_opcode, out_ra, out_rb, out_rd,
    output out_imm, out_use_a, out_use_b,
    output out_rf_we, out_mem_re, out_mem_we,
    output out_mem_byte, out_branch, out_syscall,
    output out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc,
    output flush, syscall_done, out_ready,
    input  in_ready, in_sys_wait, out_valid,
    input  out_opcode, out_ra, out_rb, out_rd,
    input  out_imm, out_use_a, out_use_b,
    input  out_rf_we, out_mem_re, out_mem_we,
    input  out_mem_byte, out_branch, out_syscall,
    input  out_pc
  );
endinterface

// File: rtl/shrimp_decode.sv
// shrimp_decode: shrimp CPU decode stage; clk, rst_n (async low), bus (shrimp_decode_if.slave).
// Optional one-entry input skid buffer: define SHRIMP_DECODE_SKID_EN.
module shrimp_decode #(
  parameter int PC_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  shrimp_decode_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    SYS_HOLD,
    SYS_WAIT
  } state_t;

  typedef enum logic [3:0] {
    OP_AND, OP_OR, OP_XOR, OP_ADD,
    OP_SUB, OP_CMP, OP_NEG, OP_RDM,
    OP_WMW, OP_WMB, OP_BEQ, OP_SYS,
    OP_SRA, OP_SRL, OP_SLL, OP_LDI
  } op_t;

  typedef struct packed {
    logic rf_we;
    logic use_a;
    logic use_b;
    logic mem_re;
    logic mem_we;
    logic mem_byte;
    logic branch;
    logic syscall;
  } ctl_t;

  function automatic ctl_t decode(input logic [3:0] op);
    ctl_t c;
    c          = '0;
    c.rf_we    = !(op inside {OP_WMW, OP_WMB,
                              OP_BEQ, OP_SYS});
    c.use_a    = !(op inside {OP_LDI, OP_SYS});
    c.use_b    = !(op inside {OP_NEG, OP_RDM,
                              OP_LDI, OP_SYS});
    c.mem_re   = (op == OP_RDM);
    c.mem_we   = (op inside {OP_WMW, OP_WMB});
    c.mem_byte = (op == OP_WMB);
    c.branch   = (op == OP_BEQ);
    c.syscall  = (op == OP_SYS);
    return c;
  endfunction

  state_t          state_q;
  state_t          state_d;
  logic            out_valid_q;
  logic [15:0]     out_instr_q;
  logic [PC_W-1:0] out_pc_q;
  logic            in_ready_i;
  logic            in_fire;
  logic            out_fire;
  logic            sys_issue;
  logic            in_is_sys;
  ctl_t            ctl;

`ifdef SHRIMP_DECODE_SKID_EN
  logic            skid_valid_q;
  logic [15:0]     skid_instr_q;
  logic [PC_W-1:0] skid_pc_q;

  // Registered-only ready: no path from out_ready.
  assign in_ready_i = !skid_valid_q
                    && (state_q == RUN);
`else
  assign in_ready_i = (state_q == RUN)
                    && (!out_valid_q
                        || bus.out_ready);
`endif

  assign in_fire   = bus.in_valid && in_ready_i;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign in_is_sys = (bus.in_instr[3:0] == OP_SYS);
  assign ctl       = decode(out_instr_q[3:0]);
  // With a skid entry an older instruction may
  // still precede the SYSCALL in the output reg.
  assign sys_issue = out_fire && ctl.syscall;

  assign bus.in_ready     = in_ready_i && rst_n;
  assign bus.in_sys_wait  = (state_q != RUN);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_opcode   = out_instr_q[3:0];
  assign bus.out_rd       = out_instr_q[7:4];
  assign bus.out_rb       = out_instr_q[11:8];
  assign bus.out_ra       = out_instr_q[15:12];
  assign bus.out_imm      = {8'h00, out_instr_q[15:8]};
  assign bus.out_pc       = out_pc_q;
  // Strobes masked so an idle stage drives zeros.
  assign bus.out_rf_we    = ctl.rf_we    && out_valid_q;
  assign bus.out_use_a    = ctl.use_a    && out_valid_q;
  assign bus.out_use_b    = ctl.use_b    && out_valid_q;
  assign bus.out_mem_re   = ctl.mem_re   && out_valid_q;
  assign bus.out_mem_we   = ctl.mem_we   && out_valid_q;
  assign bus.out_mem_byte = ctl.mem_byte && out_valid_q;
  assign bus.out_branch   = ctl.branch   && out_valid_q;
  assign bus.out_syscall  = ctl.syscall  && out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (in_fire && in_is_sys && !bus.flush)
          state_d = SYS_HOLD;
      end
      SYS_HOLD: begin
        if (bus.flush)      state_d = RUN;
        else if (sys_issue) state_d = SYS_WAIT;
      end
      SYS_WAIT: begin
        if (bus.syscall_done) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
`ifdef SHRIMP_DECODE_SKID_EN
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
`endif
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
`ifdef SHRIMP_DECODE_SKID_EN
      skid_valid_q <= 1'b0;
`endif
    end else begin
`ifdef SHRIMP_DECODE_SKID_EN
      if (!out_valid_q || bus.out_ready) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_instr_q  <= skid_instr_q;
          out_pc_q     <= skid_pc_q;
          skid_valid_q <= 1'b0;
        end else if (in_fire) begin
          out_valid_q <= 1'b1;
          out_instr_q <= bus.in_instr;
          out_pc_q    <= bus.in_pc;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (in_fire) begin
        skid_valid_q <= 1'b1;
        skid_instr_q <= bus.in_instr;
        skid_pc_q    <= bus.in_pc;
      end
`else
      if (in_fire) begin
        out_valid_q <= 1'b1;
        out_instr_q <= bus.in_instr;
        out_pc_q    <= bus.in_pc;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_shrimp_decode.sv
// tb_shrimp_decode: directed self-checking bench for shrimp_decode.
// Opcode sweep table plus hand sequences for stall, syscall, flush, reset.
module tb_shrimp_decode;

  localparam int PC_W = 16;
`ifdef SHRIMP_DECODE_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  shrimp_decode_if #(.PC_W(PC_W)) bus();

  shrimp_decode #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  ctl;
  } vec_t;

  vec_t        vt[16];
  logic [15:0] bp[3];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [7:0] ctl_now();
    return {bus.out_rf_we, bus.out_use_a,
            bus.out_use_b, bus.out_mem_re,
            bus.out_mem_we, bus.out_mem_byte,
            bus.out_branch, bus.out_syscall};
  endfunction

  function automatic logic [15:0] word_now();
    return {bus.out_ra, bus.out_rb,
            bus.out_rd, bus.out_opcode};
  endfunction

  initial begin
    int acc;
    int got;
    n_chk  = 0;
    n_fail = 0;
    // {instr, {rf_we,use_a,use_b,mem_re,mem_we,mem_byte,branch,syscall}}
    vt = '{
      '{16'hC590, 8'hE0}, '{16'hC591, 8'hE0},
      '{16'hC592, 8'hE0}, '{16'hC593, 8'hE0},
      '{16'hC594, 8'hE0}, '{16'hC595, 8'hE0},
      '{16'hC596, 8'hC0}, '{16'hC597, 8'hD0},
      '{16'hC598, 8'h68}, '{16'hC599, 8'h6C},
      '{16'hC59A, 8'h62}, '{16'hC59B, 8'h01},
      '{16'hC59C, 8'hE0}, '{16'hC59D, 8'hE0},
      '{16'hC59E, 8'hE0}, '{16'hC59F, 8'h80}
    };
    bp = '{16'h2313, 16'h1204, 16'h5670};

    rst_n            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_instr     = '0;
    bus.in_pc        = '0;
    bus.flush        = 1'b0;
    bus.syscall_done = 1'b0;
    bus.out_ready    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_ctl", ctl_now(), 0);
    chk("rst_sys_wait", bus.in_sys_wait, 0);
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_out_valid", bus.out_valid, 0);

    // Two-instruction stream with no back-pressure
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h2313;
    bus.in_pc     = 16'h0100;
    settle();
    chk("s0_in_ready", bus.in_ready, 1);
    tick();
    chk("s0_valid", bus.out_valid, 1);
    chk("s0_opcode", bus.out_opcode, 3);
    chk("s0_ra", bus.out_ra, 2);
    chk("s0_rb", bus.out_rb, 3);
    chk("s0_rd", bus.out_rd, 1);
    chk("s0_rf_we", bus.out_rf_we, 1);
    chk("s0_pc", bus.out_pc, 16'h0100);
    bus.in_instr = 16'hA54F;
    bus.in_pc    = 16'h0102;
    settle();
    chk("s1_in_ready", bus.in_ready, 1);
    tick();
    chk("s1_valid", bus.out_valid, 1);
    chk("s1_opcode", bus.out_opcode, 15);
    chk("s1_imm", bus.out_imm, 16'h00A5);
    chk("s1_use_a", bus.out_use_a, 0);
    chk("s1_rf_we", bus.out_rf_we, 1);
    chk("s1_rd", bus.out_rd, 4);
    chk("s1_pc", bus.out_pc, 16'h0102);
    bus.in_valid = 1'b0;
    tick();
    chk("s_drain", bus.out_valid, 0);

    // Back-pressure: 5 stalled cycles, 3 offered
    acc = 0;
    got = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc == 5) chk("bp_accepted", acc, EXP_ACC);
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (acc < 3);
      bus.in_instr  = (acc < 3) ? bp[acc] : 16'h0;
      settle();
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.out_valid && bus.out_ready) begin
        if (got < 3)
          chk($sformatf("bp_order%0d", got),
              word_now(), bp[got]);
        else
          chk("bp_extra", 1, 0);
        got++;
      end
      tick();
      if (got == 3 && acc == 3) break;
    end
    bus.in_valid = 1'b0;
    chk("bp_count", got, 3);
    tick();
    chk("bp_no_dup", bus.out_valid, 0);

    // SYSCALL stall; done pulse in RUN is ignored
    bus.syscall_done = 1'b1;
    tick();
    bus.syscall_done = 1'b0;
    chk("sd_run_sys_wait", bus.in_sys_wait, 0);
    settle();
    chk("sd_run_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h000B;
    bus.in_pc     = 16'h0200;
    settle();
    tick();
    chk("sys_out_syscall", bus.out_syscall, 1);
    chk("sys_hold_wait", bus.in_sys_wait, 1);
    bus.in_instr = 16'h2313;
    bus.in_pc    = 16'h0202;
    settle();
    chk("sys_hold_ready", bus.in_ready, 0);
    tick();
    chk("sys_hold_wait2", bus.in_sys_wait, 1);
    bus.out_ready = 1'b1;
    settle();
    chk("sys_issue_ready", bus.in_ready, 0);
    tick();
    chk("sys_issued", bus.out_valid, 0);
    chk("sys_wait_wait", bus.in_sys_wait, 1);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("sys_wait_ready%0d", i),
          bus.in_ready, 0);
      tick();
    end
    bus.syscall_done = 1'b1;
    settle();
    chk("sys_done_cyc_ready", bus.in_ready, 0);
    chk("sys_done_cyc_wait", bus.in_sys_wait, 1);
    tick();
    bus.syscall_done = 1'b0;
    settle();
    chk("sys_after_ready", bus.in_ready, 1);
    chk("sys_after_wait", bus.in_sys_wait, 0);
    tick();
    chk("sys_next_valid", bus.out_valid, 1);
    chk("sys_next_word", word_now(), 16'h2313);
    chk("sys_next_pc", bus.out_pc, 16'h0202);
    bus.in_valid = 1'b0;
    tick();

    // Flush with full output (and skid) entries
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h1204;
    settle();
    tick();
    bus.in_instr = 16'h5670;
    settle();
    tick();
    bus.flush    = 1'b1;
    bus.in_instr = 16'h9ABC;
    settle();
    tick();
    bus.flush = 1'b0;
    chk("fl_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    bus.in_instr  = 16'h3454;
    bus.in_pc     = 16'h0300;
    settle();
    tick();
    bus.in_valid = 1'b0;
    chk("fl_first_valid", bus.out_valid, 1);
    chk("fl_first_word", word_now(), 16'h3454);
    tick();
    chk("fl_drain", bus.out_valid, 0);

    // Handshake in the flush cycle is dropped
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h2313;
    bus.flush    = 1'b1;
    settle();
    chk("fl_drop_ready", bus.in_ready, 1);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_drop_valid", bus.out_valid, 0);

    // Flush in SYS_HOLD returns to RUN
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h000B;
    settle();
    tick();
    bus.in_valid = 1'b0;
    chk("flh_hold", bus.in_sys_wait, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flh_run", bus.in_sys_wait, 0);
    chk("flh_valid", bus.out_valid, 0);
    settle();
    chk("flh_ready", bus.in_ready, 1);

    // Opcode sweep
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = vt[i].instr;
      bus.in_pc    = 16'(16'h0400 + 2 * i);
      settle();
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("sw_ctl_op%0d", i),
          ctl_now(), vt[i].ctl);
      chk($sformatf("sw_opc_op%0d", i),
          bus.out_opcode, i);
      chk($sformatf("sw_imm_op%0d", i),
          bus.out_imm, 16'h00C5);
      tick();
      bus.syscall_done = 1'b1;
      tick();
      bus.syscall_done = 1'b0;
    end
    settle();
    chk("sw_end_ready", bus.in_ready, 1);

    // Asynchronous reset mid-operation (in SYS_HOLD)
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h000B;
    bus.in_pc     = 16'h0500;
    settle();
    tick();
    bus.in_valid = 1'b0;
    chk("ar_pre_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_ctl", ctl_now(), 0);
    chk("ar_opcode", bus.out_opcode, 0);
    chk("ar_pc", bus.out_pc, 0);
    chk("ar_sys_wait", bus.in_sys_wait, 0);
    chk("ar_in_ready", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("ar_rel_ready", bus.in_ready, 1);
    chk("ar_rel_wait", bus.in_sys_wait, 0);
    tick();
    chk("ar_rel_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shrimp_decode.md
# shrimp_decode

Instruction decode stage for the shrimp CPU. Accepts raw 16-bit instruction words and their PC from fetch over a valid/ready handshake, splits them into opcode, register and immediate fields, and expands each opcode into control strobes for the register file, ALU and memory stages. Holds at most one SYSCALL in flight: fetch is stalled until the system side signals completion.

## Interface
- `PC_W`, default 16: width of the PC passed through with each instruction.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  decode accepts this cycle.
- `in_instr`  in  16  instruction word: [15:12] regA, [11:8] regB (or [15:8] immediate), [7:4] regDst, [3:0] opcode.
- `in_pc`  in  PC_W  PC of `in_instr`.
- `flush`  in  1  drop all held, not-yet-issued instructions.
- `syscall_done`  in  1  single-cycle pulse: outstanding SYSCALL has finished.
- `out_valid`  out  1  decoded instruction available.
- `out_ready`  in  1  downstream accepts.
- `out_opcode`  out  4  opcode (opcode enum encoding, AND=0 … LOAD_IMM=15).
- `out_ra`, `out_rb`, `out_rd`  out  4 each  regA, regB, regDst fields.
- `out_imm`  out  16  {8'h00, instr[15:8]}.
- `out_use_a`, `out_use_b`  out  1 each  regA / regB read required.
- `out_rf_we`  out  1  instruction writes `out_rd`.
- `out_mem_re`, `out_mem_we`, `out_mem_byte`  out  1 each  memory read, write, byte-write.
- `out_branch`, `out_syscall`  out  1 each.
- `out_pc`  out  PC_W  PC of the decoded instruction.
- `in_sys_wait`  out  1  high in SYS_HOLD or SYS_WAIT.

## Operation
- Field extraction and control generation are a pure function of the stored word; all outputs come from registers, not from `in_instr`.
- `rf_we` = 1 for AND, OR, XOR, ADD, SUB, CMP, NEG, READ_MEM, SRA, SRL, SLL, LOAD_IMM; 0 for WRITE_MEM_WORD, WRITE_MEM_BYTE, BRANCH_EQ, SYSCALL.
- `use_a` = 1 for every opcode except LOAD_IMM and SYSCALL. `use_b` = 0 for NEG, READ_MEM, LOAD_IMM, SYSCALL; otherwise 1.
- `mem_re` only for READ_MEM. `mem_we` for both WRITE_MEM opcodes. `mem_byte` only for WRITE_MEM_BYTE. `branch` only for BRANCH_EQ. `syscall` only for SYSCALL.
- FSM:
  - RUN: normal flow. Accepting a SYSCALL moves to SYS_HOLD.
  - SYS_HOLD: the SYSCALL is held, not yet issued; `in_ready`=0. Output handshake of the SYSCALL moves to SYS_WAIT. `flush` returns to RUN.
  - SYS_WAIT: `in_ready`=0; `syscall_done` returns to RUN. `flush` has no effect on this state.
- `syscall_done` is ignored outside SYS_WAIT.
- `flush` clears `out_valid` and any buffered entry the same edge. An input handshake in the flush cycle is also dropped.
- Reset: state RUN. All outputs 0, except `in_ready` = 1 after reset release.

## Timing
- Latency: input handshake at edge N gives `out_valid`=1 after edge N, presenting that instruction. Throughput is 1 instruction/cycle while `out_ready`=1.
- Handshake: transfer occurs when valid && ready. Once asserted, `out_valid` and all out_* stay stable until the transfer or a `flush`.
- The instruction following a SYSCALL is never accepted before the cycle after `syscall_done`. Earliest re-accept: `in_ready`=1 in the cycle after the `syscall_done` pulse.
- Reset mid-operation: an asynchronous return to reset values, dropping held instructions.

## Configuration
- `SHRIMP_DECODE_SKID_EN` defined:
  - Adds a one-entry skid buffer, so `in_ready` is a flop output: `in_ready` = skid empty && state RUN.
  - Input accepted while `out_ready`=0 goes to the skid entry. It moves to the output register on the next output transfer, preserving order.
- Undefined:
  - No skid entry. `in_ready` = (state==RUN) && (!out_valid || out_ready), which is combinational from `out_ready`.

## Test plan
- Stream ADD r1=r2+r3 (0x2313), LOAD_IMM r4=0xA5 (0xA54F), `out_ready`=1 -> two consecutive outputs. First: opcode 3, ra 2, rb 3, rd 1, rf_we 1. Second: imm 0x00A5, use_a 0, rf_we 1.
- Back-pressure: `out_ready`=0 for 5 cycles while 3 instructions are offered -> no loss, duplication or reordering. With SKID_EN, exactly 2 are accepted before `in_ready` drops.
- SYSCALL 0x000B then ADD -> ADD not accepted until the cycle after `syscall_done`. `in_sys_wait`=1 throughout. A `syscall_done` pulse while in RUN has no effect.
- `flush` with a valid output and a full skid entry -> `out_valid`=0 next cycle and the next accepted instruction is the first output. `flush` in SYS_HOLD returns to RUN.
- Sweep all 16 opcodes -> rf_we, use_a, use_b, mem_re, mem_we, mem_byte, branch and syscall match the Operation lists exactly.
- Assert `rst_n` mid-stream -> all outputs 0 asynchronously, state RUN after release.
